// File: rtl/magma_cipher_iter.sv
// rtl/magma_cipher_iter.sv - iterative Magma (GOST R 34.12-2015) block cipher core
// Runs ROUNDS_PER_CYCLE Feistel rounds per clock; valid/ready on both sides.
module magma_cipher_iter #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [255:0] in_key,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         busy
);

  localparam bit RPC_OK = (ROUNDS_PER_CYCLE == 1) || (ROUNDS_PER_CYCLE == 2) ||
                          (ROUNDS_PER_CYCLE == 4) || (ROUNDS_PER_CYCLE == 8) ||
                          (ROUNDS_PER_CYCLE == 16) || (ROUNDS_PER_CYCLE == 32);
  generate
    if (!RPC_OK) begin : g_bad_rpc
      $error("magma_cipher_iter: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  localparam logic [5:0] RPC = 6'(ROUNDS_PER_CYCLE);

  // tc26 param-Z S-boxes; entry v of Pi_j sits at bits [4v+3:4v]
  localparam logic [63:0] SBOX [8] = '{
    64'h1f30_7d8e_9b5a_264c,
    64'hf0db_74e1_c5a9_3286,
    64'h069c_471e_daf2_853b,
    64'hb9e3_5a07_6f4d_128c,
    64'hc24b_e390_d618_a5f7,
    64'h0e34_187b_ac29_6fd5,
    64'h73ad_0b4f_c196_52e8,
    64'h2bc9_6af4_3850_de71
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [5:0]     rnd_q, rnd_d;
  logic [31:0]    a1_q, a0_q, a1_d, a0_d;
  logic [255:0]   key_q;
  logic           dec_q;
  logic [63:0]    out_block_q;
  logic           accept;

  function automatic logic [31:0] g_fn(input logic [31:0] x);
    logic [31:0] s;
    logic [63:0] row;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      row = SBOX[j];
      s[4*j +: 4] = row[{x[4*j +: 4], 2'b00} +: 4];
    end
    return {s[20:0], s[31:21]};
  endfunction

  // K1..K8 forward for the first 24 encrypt / 8 decrypt rounds, then K8..K1
  function automatic logic [31:0] round_key(input logic [255:0] key,
                                            input logic [4:0] i,
                                            input logic dec);
    logic [2:0] idx;
    if (dec) idx = (i < 5'd8)  ? i[2:0] : ~i[2:0];
    else     idx = (i < 5'd24) ? i[2:0] : ~i[2:0];
    return key[{~idx, 5'b00000} +: 32];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (rnd_d == 6'd32) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = in_valid ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign accept    = in_valid && in_ready;
  assign out_block = out_block_q;

  always_comb begin : p_rounds
    logic [31:0] x1, x0, t;
    x1 = a1_q;
    x0 = a0_q;
    t  = '0;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      t  = x1 ^ g_fn(x0 + round_key(key_q, rnd_q[4:0] + 5'(r), dec_q));
      x1 = x0;
      x0 = t;
    end
    a1_d  = x1;
    a0_d  = x0;
    rnd_d = rnd_q + RPC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q        <= '0;
      a0_q        <= '0;
      key_q       <= '0;
      dec_q       <= 1'b0;
      rnd_q       <= '0;
      out_block_q <= '0;
    end else if (accept) begin
      a1_q  <= in_block[63:32];
      a0_q  <= in_block[31:0];
      key_q <= in_key;
      dec_q <= in_decrypt;
      rnd_q <= '0;
    end else if (state_q == S_RUN) begin
      a1_q  <= a1_d;
      a0_q  <= a0_d;
      rnd_q <= rnd_d;
      // Final half swap undoes the swap the last round applied
      if (rnd_d == 6'd32) out_block_q <= {a0_d, a1_d};
    end
  end

endmodule

// File: tb/tb_magma_cipher_iter.sv
// tb/tb_magma_cipher_iter.sv - self-checking bench for magma_cipher_iter
// Reference-model scoreboard on the 1-round core plus latency checks on 4- and 32-round cores.
module tb_magma_cipher_iter;

  localparam logic [255:0] KEY  = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [255:0] KEY2 = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
  localparam logic [63:0]  PT   = 64'hfedcba9876543210;
  localparam logic [63:0]  CT   = 64'h4ee901e5c2d8ca3d;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0]  in_block, out_block;
  logic [255:0] in_key;
  logic v4, ir4, ov4, b4, v32, ir32, ov32, b32, lat_ready;
  logic [63:0] ob4, ob32;

  int n_cmp = 0;
  int n_fail = 0;
  int n_deliv = 0;

  always #5 clk = ~clk;

  magma_cipher_iter #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy));

  magma_cipher_iter #(.ROUNDS_PER_CYCLE(4)) u_r4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4),
    .in_block(in_block), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(ov4), .out_ready(lat_ready), .out_block(ob4), .busy(b4));

  magma_cipher_iter #(.ROUNDS_PER_CYCLE(32)) u_r32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32),
    .in_block(in_block), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(ov32), .out_ready(lat_ready), .out_block(ob32), .busy(b32));

  int pi [8][16] = '{
    '{12, 4, 6, 2, 10, 5, 11, 9, 14, 8, 13, 7, 0, 3, 15, 1},
    '{6, 8, 2, 3, 9, 10, 5, 12, 1, 14, 4, 7, 11, 13, 0, 15},
    '{11, 3, 5, 8, 2, 15, 10, 13, 14, 1, 7, 4, 12, 9, 6, 0},
    '{12, 8, 2, 1, 13, 4, 15, 6, 7, 0, 10, 5, 3, 14, 9, 11},
    '{7, 15, 5, 10, 8, 1, 6, 13, 0, 9, 3, 14, 11, 4, 2, 12},
    '{5, 13, 15, 6, 9, 2, 12, 10, 11, 7, 8, 1, 4, 3, 14, 0},
    '{8, 14, 2, 5, 6, 9, 1, 12, 15, 4, 11, 0, 13, 10, 3, 7},
    '{1, 7, 14, 13, 0, 5, 8, 3, 4, 15, 10, 6, 9, 12, 11, 2}
  };

  function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s, y;
    s = a + k;
    y = '0;
    for (int j = 0; j < 8; j++) y = y | (32'(pi[j][s[4*j +: 4]]) << (4*j));
    return (y << 11) | (y >> 21);
  endfunction

  // Textbook form: 31 swapped rounds then an unswapped one; decryption reverses the schedule
  function automatic logic [63:0] magma_ref(input logic [255:0] key, input logic [63:0] blk,
                                            input logic dec);
    logic [31:0] kw [8];
    logic [31:0] ks [32];
    logic [31:0] a1, a0, tmp;
    for (int i = 0; i < 8; i++) kw[i] = key[255 - 32*i -: 32];
    for (int i = 0; i < 32; i++) ks[i] = (i < 24) ? kw[i % 8] : kw[7 - (i % 8)];
    if (dec) begin
      for (int i = 0; i < 16; i++) begin
        tmp = ks[i]; ks[i] = ks[31 - i]; ks[31 - i] = tmp;
      end
    end
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int i = 0; i < 31; i++) begin
      tmp = a0;
      a0  = ref_g(a0, ks[i]) ^ a1;
      a1  = tmp;
    end
    return {ref_g(a0, ks[31]) ^ a1, a0};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  // Scoreboard: predicts outputs of u_dut after each coming edge
  logic        m_pending = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_q [$];

  always @(negedge clk) begin
    logic exp_ov, exp_ir, deliver, acc;
    if (rst) begin
      check64("rst out_valid", {63'd0, out_valid}, 64'd0);
      check64("rst busy", {63'd0, busy}, 64'd0);
      check64("rst out_block", out_block, 64'd0);
      m_pending = 1'b0;
      m_cnt = 0;
      m_q.delete();
    end else begin
      exp_ov = m_pending && (m_cnt == 0);
      exp_ir = !m_pending || (exp_ov && out_ready);
      check64("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      check64("busy", {63'd0, busy}, {63'd0, m_pending});
      check64("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
      if (exp_ov && m_q.size() > 0) check64("out_block", out_block, m_q[0]);
      deliver = exp_ov && out_ready;
      acc = in_valid && exp_ir;
      if (deliver) begin
        void'(m_q.pop_front());
        m_pending = 1'b0;
        n_deliv++;
      end
      if (acc) begin
        m_q.push_back(magma_ref(in_key, in_block, in_decrypt));
        m_pending = 1'b1;
        m_cnt = 32;
      end else if (m_pending && m_cnt > 0) begin
        m_cnt--;
      end
    end
  end

  task automatic send(input logic [255:0] k, input logic [63:0] b, input logic d);
    int  w;
    logic acc;
    in_key = k; in_block = b; in_decrypt = d; in_valid = 1'b1;
    w = 0; acc = 1'b0;
    while (!acc && w < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      w++;
    end
    in_valid = 1'b0;
    if (!acc) timeout_fail("send accept");
  endtask

  task automatic wait_result(input string name, input int n, input logic [63:0] exp);
    int   k;
    logic ok;
    k = 0; ok = 1'b1;
    while (!out_valid && k < 200) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) timeout_fail({name, " out_valid"});
    else begin
      check_int({name, " latency"}, k, n);
      check_int({name, " ready0/busy1 while running"}, int'(ok), 1);
      check64({name, " block"}, out_block, exp);
    end
  endtask

  logic [255:0] s_key [8] = '{KEY, KEY, KEY2, KEY, KEY2, KEY2, KEY, KEY2};
  logic [63:0]  s_blk [8] = '{PT, CT, 64'h0, 64'hffff_ffff_ffff_ffff,
                              64'h0123_4567_89ab_cdef, 64'h8000_0000_0000_0001, CT, PT};
  logic         s_dec [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         stream_on;

  initial begin
    int k, base;
    logic ok;
    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_key = '0; in_decrypt = 1'b0;
    out_ready = 1'b0; v4 = 1'b0; v32 = 1'b0; lat_ready = 1'b1; stream_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check64("reset in_ready", {63'd0, in_ready}, 64'd1);
    check64("reset out_block", out_block, 64'd0);
    check64("reset r4/r32 in_ready", {62'd0, ir4, ir32}, 64'd3);

    check64("model enc vector", magma_ref(KEY, PT, 1'b0), CT);
    check64("model dec vector", magma_ref(KEY, CT, 1'b1), PT);

    @(posedge clk); #1;
    out_ready = 1'b1;
    send(KEY, PT, 1'b0);
    wait_result("enc r1", 32, CT);
    send(KEY, CT, 1'b1);
    wait_result("dec r1", 32, PT);

    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      in_key = KEY; in_block = PT; in_decrypt = 1'b0;
      if (c == 0) v4 = 1'b1; else v32 = 1'b1;
      @(posedge clk); #1;
      v4 = 1'b0; v32 = 1'b0;
      k = 0; ok = 1'b1;
      while (!(c == 0 ? ov4 : ov32) && k < 200) begin
        if ((c == 0 ? ir4 : ir32) !== 1'b0 || (c == 0 ? b4 : b32) !== 1'b1) ok = 1'b0;
        @(posedge clk); #1;
        k++;
      end
      check_int(c == 0 ? "r4 latency" : "r32 latency", k, c == 0 ? 8 : 1);
      check_int(c == 0 ? "r4 ready0/busy1" : "r32 ready0/busy1", int'(ok), 1);
      check64(c == 0 ? "r4 block" : "r32 block", c == 0 ? ob4 : ob32, CT);
    end

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(KEY, PT, 1'b0);
    wait_result("bp first", 32, CT);
    for (int i = 0; i < 10; i++) begin
      check64("bp hold block", out_block, CT);
      check64("bp hold valid/ready", {62'd0, out_valid, in_ready}, 64'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(KEY, CT, 1'b1);
    check64("bp same-clock transfer", {62'd0, out_valid, busy}, 64'd1);
    wait_result("bp second", 32, PT);

    send(KEY, PT, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check64("async rst valid/busy", {62'd0, out_valid, busy}, 64'd0);
    check64("async rst block", out_block, 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check64("post rst idle", {62'd0, out_valid, busy}, 64'd0);
    send(KEY, PT, 1'b0);
    wait_result("after rst enc", 32, CT);

    @(posedge clk); #1;
    base = n_deliv;
    stream_on = 1'b1;
    fork
      begin
        while (stream_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int t = 0; t < 8; t++) send(s_key[t], s_blk[t], s_dec[t]);
        k = 0;
        while ((m_pending || m_q.size() != 0) && k < 2000) begin
          @(posedge clk); #1;
          k++;
        end
        if (m_pending || m_q.size() != 0) timeout_fail("stream drain");
        stream_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    check_int("stream delivered count", n_deliv - base, 8);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
